avg_capture_sched: RTL and testbench
====================================

Name: avg_capture_sched

Overview:
Capture scheduler in front of the averager. Takes the packed dual-channel ADC word (ch1 in bits [15:0], ch2 in bits [31:16]) and selects the channel per trace. Arms on a trigger, captures cfg_samples sign-extended samples per trace, and repeats for cfg_averages traces. Output is a 32-bit AXI-Stream that feeds the averager core.

Parameters:
ADC_DATA_WIDTH, 16, width of one channel in adc_data
AXIS_TDATA_WIDTH, 32, width of adc_data and m_axis_tdata
SAMPLE_CNT_WIDTH, 16, width of cfg_samples and the sample counter
AVG_CNT_WIDTH, 16, width of cfg_averages and trace_cnt

Ports:
aclk  in  1  single clock, all logic rising-edge
aresetn  in  1  synchronous active-low reset
adc_data  in  32  {ch2, ch1} packed ADC word
adc_valid  in  1  adc_data qualifier
trig_in  in  1  level trigger; the rising edge is used
start  in  1  pulse; latches config and arms
abort  in  1  pulse; returns to IDLE
cfg_mode  in  2  0=ch1, 1=ch2, 2=alternate per trace (even trace ch1, odd trace ch2), 3=ch1
cfg_samples  in  SAMPLE_CNT_WIDTH  samples per trace
cfg_averages  in  AVG_CNT_WIDTH  traces per run
m_axis_tdata  out  32  sign-extended sample
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tlast  out  1  last sample of trace
m_axis_tuser  out  1  channel id of sample (0=ch1, 1=ch2)
busy  out  1  high in ARMED/CAPTURE
done  out  1  one-cycle pulse at end of run
overrun  out  1  sticky: sample dropped due to backpressure
trace_cnt  out  AVG_CNT_WIDTH  completed traces in current run

Behaviour:
- Reset (aresetn=0 at a clock edge): state IDLE; all outputs 0; counters 0; trigger edge register 0.
- Trigger edge: trig_q <= trig_in every cycle. An edge is trig_in & ~trig_q. The edge register runs in all states.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE -> ARMED on start:
  - latch cfg_mode, cfg_samples, cfg_averages;
  - clear trace_cnt, sample counter and overrun.
- IDLE -> DONE if start arrives with cfg_samples==0 or cfg_averages==0; no data is emitted.
- start outside IDLE is ignored. Config inputs are ignored outside the start cycle.
- ARMED -> CAPTURE on a trigger edge seen while ARMED. An edge in the same cycle as start is ignored (the FSM is still IDLE).
- CAPTURE: each cycle with adc_valid=1 captures one sample and increments the sample counter. Triggers are ignored.
- Channel per trace:
  - mode 0 or 3 → ch1;
  - mode 1 → ch2;
  - mode 2 → ch1 when trace_cnt[0]==0, ch2 otherwise.
- Width rule: tdata = selected 16-bit field sign-extended to exactly 32 bits, i.e. 16 copies of bit 15 (ch1) or bit 31 (ch2).
- Latency: a sample accepted at cycle t appears on m_axis_* at t+1. tuser is the channel id. tlast=1 on sample number cfg_samples of the trace.
- After the last sample of a trace:
  - trace_cnt increments in the same cycle;
  - if the new trace_cnt == cfg_averages → DONE, else → ARMED.
- DONE: done=1 for exactly one cycle, then IDLE. trace_cnt holds until the next start.
- Output register, AXIS rules:
  - tvalid is cleared on a cycle with tvalid & tready and no new sample;
  - while tvalid & ~tready, tdata/tlast/tuser hold stable;
  - if a new sample arrives while tvalid & ~tready, the new sample is dropped and overrun is set. The sample still counts.
  - If the dropped sample is the last of a trace, the trace still completes, and the held word keeps its own tlast.
  - A simultaneous tready and new sample replaces the register, and tvalid stays 1.
- abort (any state): next state IDLE; tvalid cleared; busy=0; no done pulse; trace_cnt and overrun hold. abort has priority over start and trigger in the same cycle.
- Reset mid-run: identical to power-on reset; no done pulse.
- busy = (state==ARMED || state==CAPTURE), registered with the state.

Test Plan:
- Mode 0, samples=4, averages=2, adc_data=0x7FFF_8001 constant, tready=1, two trigger edges → 8 beats of tdata=0xFFFF_8001, tuser=0; tlast on beats 4 and 8; done pulse once; trace_cnt=2; overrun=0.
- Mode 2, samples=3, averages=2, adc_data=0x8000_0005 → trace 0 gives 3×0x0000_0005 (tuser=0); trace 1 gives 3×0xFFFF_8000 (tuser=1).
- Mode 1, samples=8, averages=1, tready=0 for 4 cycles mid-trace → first stalled word held stable; 3 samples dropped; overrun=1; trace ends after 8 accepted adc_valid cycles with done pulse.
- Triggers during CAPTURE and trig_in held high continuously → only the first edge starts the trace; the run waits in ARMED (busy=1) until trig_in falls and rises again.
- start with cfg_samples=0 → done pulses 2 cycles later; no tvalid; busy stays 0.
- abort mid-CAPTURE, then aresetn=0 for 1 cycle mid-ARMED on a second run → IDLE, tvalid=0, no done; after reset all outputs 0 and trace_cnt=0.

Source files
------------

// File: rtl/avg_capture_sched_if.sv
// avg_capture_sched_if
// AXI-Stream link from the capture scheduler to the averager core.
//   tdata  : sign-extended sample word
//   tvalid : word in tdata is valid
//   tready : sink accepts the word this cycle
//   tlast  : last sample of a trace
//   tuser  : channel id of the sample (0 = ch1, 1 = ch2)
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both 1. Once tvalid is 1, tdata/tlast/tuser stay stable until that
// transfer happens or the source is aborted/reset.
interface avg_capture_sched_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/avg_capture_sched.sv
// avg_capture_sched
// Capture scheduler in front of the averager. Selects one channel of the
// packed {ch2, ch1} ADC word per trace, arms on a trigger rising edge,
// captures cfg_samples sign-extended samples per trace and repeats for
// cfg_averages traces, streaming each sample out on AXI-Stream.
// Ports:
//   aclk, aresetn         : clock, synchronous active-low reset
//   adc_data, adc_valid   : packed ADC word {ch2, ch1} and its qualifier
//   trig_in               : level trigger, rising edge starts a trace
//   start, abort          : run control pulses (abort has priority)
//   cfg_mode              : 0/3 = ch1, 1 = ch2, 2 = alternate per trace
//   cfg_samples           : samples per trace
//   cfg_averages          : traces per run
//   m_axis                : sample stream (master side)
//   busy                  : run in progress (ARMED or CAPTURE)
//   done                  : one-cycle pulse at end of a run
//   overrun               : sticky, a sample was dropped under backpressure
//   trace_cnt             : completed traces in the current run
//   dbg_state             : current FSM state encoding
module avg_capture_sched #(
  parameter int ADC_DATA_WIDTH   = 16,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLE_CNT_WIDTH = 16,
  parameter int AVG_CNT_WIDTH    = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] adc_data,
  input  logic                        adc_valid,
  input  logic                        trig_in,
  input  logic                        start,
  input  logic                        abort,
  input  logic [1:0]                  cfg_mode,
  input  logic [SAMPLE_CNT_WIDTH-1:0] cfg_samples,
  input  logic [AVG_CNT_WIDTH-1:0]    cfg_averages,
  avg_capture_sched_if.master         m_axis,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  output logic [AVG_CNT_WIDTH-1:0]    trace_cnt,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int EXT_W = AXIS_TDATA_WIDTH - ADC_DATA_WIDTH;

  state_t state, state_nx;

  logic                        trig_q;
  logic                        trig_edge;
  logic [1:0]                  mode_q;
  logic [SAMPLE_CNT_WIDTH-1:0] samples_q;
  logic [AVG_CNT_WIDTH-1:0]    averages_q;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt_inc;
  logic [AVG_CNT_WIDTH-1:0]    trace_inc;

  logic                        start_ok;
  logic                        cfg_zero;
  logic                        accept;
  logic                        last_sample;
  logic                        sel_ch2;
  logic [ADC_DATA_WIDTH-1:0]   ch1;
  logic [ADC_DATA_WIDTH-1:0]   ch2;
  logic [AXIS_TDATA_WIDTH-1:0] sample_word;

  logic [AXIS_TDATA_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_last;
  logic                        out_user;

  assign trig_edge      = trig_in & ~trig_q;
  assign sample_cnt_inc = sample_cnt + 1'b1;
  assign trace_inc      = trace_cnt + 1'b1;
  assign start_ok       = (state == S_IDLE) & start & ~abort;
  assign cfg_zero       = (cfg_samples == '0) | (cfg_averages == '0);
  assign accept         = (state == S_CAPTURE) & adc_valid & ~abort;
  assign last_sample    = accept & (sample_cnt_inc == samples_q);

  assign ch1 = adc_data[ADC_DATA_WIDTH-1:0];
  assign ch2 = adc_data[2*ADC_DATA_WIDTH-1:ADC_DATA_WIDTH];

  // Channel choice follows the trace index, so in alternate mode the
  // channel flips when trace_cnt advances at the end of each trace.
  always_comb begin
    sel_ch2 = 1'b0;
    case (mode_q)
      2'd1:    sel_ch2 = 1'b1;
      2'd2:    sel_ch2 = trace_cnt[0];
      default: sel_ch2 = 1'b0;
    endcase
  end

  assign sample_word = sel_ch2 ? {{EXT_W{ch2[ADC_DATA_WIDTH-1]}}, ch2}
                               : {{EXT_W{ch1[ADC_DATA_WIDTH-1]}}, ch1};

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nx = cfg_zero ? S_DONE : S_ARMED;
        S_ARMED:   if (trig_edge) state_nx = S_CAPTURE;
        S_CAPTURE: if (last_sample) state_nx = (trace_inc == averages_q) ? S_DONE : S_ARMED;
        S_DONE:    state_nx = S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // Datapath, counters, status and output register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      trig_q     <= 1'b0;
      mode_q     <= '0;
      samples_q  <= '0;
      averages_q <= '0;
      sample_cnt <= '0;
      trace_cnt  <= '0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_user   <= 1'b0;
    end else begin
      trig_q <= trig_in;
      busy   <= (state_nx == S_ARMED) | (state_nx == S_CAPTURE);
      // done follows the DONE state by one cycle; abort suppresses it
      done   <= (state == S_DONE) & ~abort;

      if (start_ok) begin
        mode_q     <= cfg_mode;
        samples_q  <= cfg_samples;
        averages_q <= cfg_averages;
        sample_cnt <= '0;
        trace_cnt  <= '0;
        overrun    <= 1'b0;
      end

      // Dropped samples still count toward the trace length.
      if (accept) begin
        sample_cnt <= last_sample ? '0 : sample_cnt_inc;
        if (last_sample) trace_cnt <= trace_inc;
      end

      if (abort) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        if (!out_valid || m_axis.tready) begin
          out_data  <= sample_word;
          out_last  <= last_sample;
          out_user  <= sel_ch2;
          out_valid <= 1'b1;
        end else begin
          // Held word keeps its own tlast; the new sample is lost.
          overrun <= 1'b1;
        end
      end else if (out_valid && m_axis.tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tuser  = out_user;
  assign dbg_state     = state;

endmodule

// File: tb/tb_avg_capture_sched.sv
module tb_avg_capture_sched;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        trig_in = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_samples = '0;
  logic [15:0] cfg_averages = '0;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] trace_cnt;
  logic [1:0]  dbg_state;

  avg_capture_sched_if #(.W(32)) m_axis ();

  // clock / reset block
  always #5 aclk = ~aclk;

  avg_capture_sched dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .trig_in      (trig_in),
    .start        (start),
    .abort        (abort),
    .cfg_mode     (cfg_mode),
    .cfg_samples  (cfg_samples),
    .cfg_averages (cfg_averages),
    .m_axis       (m_axis),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .trace_cnt    (trace_cnt),
    .dbg_state    (dbg_state)
  );

  // scoreboard: {tlast, tuser, tdata}
  logic [33:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int beat_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Beats are observed on the falling edge ahead of the transferring edge.
  always @(negedge aclk) begin
    if (aresetn && done) done_cnt++;
    if (aresetn && m_axis.tvalid && m_axis.tready) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL extra_beat observed=%0h expected=none", m_axis.tdata);
      end else begin
        check("beat", {30'b0, m_axis.tlast, m_axis.tuser, m_axis.tdata}, {30'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic last, input logic user, input logic [31:0] d);
    exp_q.push_back({last, user, d});
  endtask

  task automatic do_start(input logic [1:0] mode, input logic [15:0] ns, input logic [15:0] na);
    cfg_mode = mode;
    cfg_samples = ns;
    cfg_averages = na;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode = 2'd3;
    cfg_samples = 16'hffff;
    cfg_averages = 16'hffff;
  endtask

  task automatic trig_pulse();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d, input logic rdy, input logic v);
    adc_data = d;
    m_axis.tready = rdy;
    adc_valid = v;
    tick();
  endtask

  logic [31:0] d [1:8];
  logic [31:0] held;

  initial begin
    m_axis.tready = 1'b1;
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    check("rst_state", dbg_state, 0);
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_trace_cnt", trace_cnt, 0);

    // mode 0: two traces of four ch1 samples
    adc_data = 32'h7fff_8001;
    do_start(2'd0, 16'd4, 16'd2);
    check("t1_busy", busy, 1);
    check("t1_armed", dbg_state, 1);
    for (int t = 0; t < 2; t++) begin
      trig_pulse();
      check("t1_capture", dbg_state, 2);
      adc_valid = 1'b1;
      for (int s = 1; s <= 4; s++) begin
        push(s == 4, 1'b0, 32'hffff_8001);
        tick();
      end
      adc_valid = 1'b0;
      if (t == 0) check("t1_rearmed", dbg_state, 1);
    end
    tick(); tick(); tick();
    check("t1_done_cnt", done_cnt, 1);
    check("t1_trace_cnt", trace_cnt, 2);
    check("t1_overrun", overrun, 0);
    check("t1_beats", beat_cnt, 8);

    // mode 2: alternate channel per trace
    adc_data = 32'h8000_0005;
    do_start(2'd2, 16'd3, 16'd2);
    for (int t = 0; t < 2; t++) begin
      trig_pulse();
      adc_valid = 1'b1;
      for (int s = 1; s <= 3; s++) begin
        push(s == 3, t[0], (t == 0) ? 32'h0000_0005 : 32'hffff_8000);
        tick();
      end
      adc_valid = 1'b0;
    end
    tick(); tick();
    check("t2_done_cnt", done_cnt, 2);
    check("t2_beats", beat_cnt, 14);

    // mode 1 with a backpressure stall mid-trace
    for (int i = 1; i <= 8; i++) d[i] = $urandom;
    do_start(2'd1, 16'd8, 16'd1);
    trig_pulse();
    push(1'b0, 1'b1, sx(d[1][31:16])); feed(d[1], 1'b1, 1'b1);
    push(1'b0, 1'b1, sx(d[2][31:16])); feed(d[2], 1'b1, 1'b1);
    held = sx(d[2][31:16]);
    feed(32'h0, 1'b0, 1'b0);
    check("t3_hold_data", m_axis.tdata, held);
    for (int i = 3; i <= 5; i++) begin
      feed(d[i], 1'b0, 1'b1);
      check("t3_hold_data", m_axis.tdata, held);
      check("t3_hold_valid", m_axis.tvalid, 1);
      check("t3_hold_last", m_axis.tlast, 0);
    end
    check("t3_overrun", overrun, 1);
    push(1'b0, 1'b1, sx(d[6][31:16])); feed(d[6], 1'b1, 1'b1);
    push(1'b0, 1'b1, sx(d[7][31:16])); feed(d[7], 1'b1, 1'b1);
    push(1'b1, 1'b1, sx(d[8][31:16])); feed(d[8], 1'b1, 1'b1);
    adc_valid = 1'b0;
    tick(); tick();
    check("t3_done_cnt", done_cnt, 3);
    check("t3_trace_cnt", trace_cnt, 1);
    check("t3_beats", beat_cnt, 19);

    // trigger edges during CAPTURE and a held trigger are ignored
    adc_data = 32'h1234_c321;
    do_start(2'd0, 16'd2, 16'd2);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0; adc_valid = 1'b1;
    push(1'b0, 1'b0, 32'hffff_c321);
    tick();
    trig_in = 1'b1;
    push(1'b1, 1'b0, 32'hffff_c321);
    tick();
    tick(); tick(); tick();
    adc_valid = 1'b0;
    check("t4_wait_armed", dbg_state, 1);
    check("t4_wait_busy", busy, 1);
    check("t4_trace_cnt", trace_cnt, 1);
    trig_in = 1'b0;
    tick();
    trig_pulse();
    check("t4_capture", dbg_state, 2);
    adc_valid = 1'b1;
    push(1'b0, 1'b0, 32'hffff_c321); tick();
    push(1'b1, 1'b0, 32'hffff_c321); tick();
    adc_valid = 1'b0;
    tick(); tick();
    check("t4_done_cnt", done_cnt, 4);
    check("t4_trace_cnt2", trace_cnt, 2);

    // zero-length runs finish without data
    do_start(2'd0, 16'd0, 16'd5);
    check("t5_done_early", done, 0);
    check("t5_busy", busy, 0);
    tick();
    check("t5_done_pulse", done, 1);
    tick();
    check("t5_done_end", done, 0);
    check("t5_tvalid", m_axis.tvalid, 0);
    do_start(2'd0, 16'd3, 16'd0);
    tick();
    check("t5_done_pulse_avg0", done, 1);
    tick();
    check("t5_done_cnt", done_cnt, 6);

    // abort mid-CAPTURE after one completed trace
    adc_data = 32'h0000_0011;
    do_start(2'd0, 16'd3, 16'd3);
    trig_pulse();
    adc_valid = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      push(s == 3, 1'b0, 32'h0000_0011);
      tick();
    end
    adc_valid = 1'b0;
    trig_pulse();
    m_axis.tready = 1'b0;
    adc_valid = 1'b1;
    tick(); tick();
    adc_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_state", dbg_state, 0);
    check("t6_abort_tvalid", m_axis.tvalid, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_overrun", overrun, 1);
    check("t6_abort_trace_cnt", trace_cnt, 1);
    tick(); tick();
    m_axis.tready = 1'b1;
    check("t6_abort_no_done", done_cnt, 6);

    // reset while ARMED on a second run
    do_start(2'd0, 16'd2, 16'd1);
    check("t6_armed", dbg_state, 1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("t6_rst_state", dbg_state, 0);
    check("t6_rst_tvalid", m_axis.tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_trace_cnt", trace_cnt, 0);
    tick(); tick();
    check("t6_rst_no_done", done_cnt, 6);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_beats", beat_cnt, 26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
